// File: rtl/restoring_divider_module.sv
// ---------------------------------------------------------------------------
// restoring_divider_module
//
// Purpose:
//   Multi-cycle unsigned restoring divider. It produces one quotient bit per
//   clock by trial subtraction of the divisor from a width+1-bit partial
//   remainder. A divide is requested with a start/busy/done handshake.
//   Divide by zero skips the iteration and reports all-ones quotient,
//   dividend as remainder, and div_zero.
//
// Ports:
//   clk        in   1      rising-edge clock
//   reset_n    in   1      asynchronous active-low reset
//   start      in   1      divide request, sampled only while idle
//   dividend   in   width  unsigned dividend, captured on accept
//   divisor    in   width  unsigned divisor, captured on accept
//   busy       out  1      high from accept until the result is published
//   done       out  1      one-cycle pulse, results valid
//   quotient   out  width  result quotient, held until the next result
//   remainder  out  width  result remainder, held until the next result
//   div_zero   out  1      divisor was zero, held until the next accept
// ---------------------------------------------------------------------------
module restoring_divider_module #(
    parameter int width = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [width-1:0] dividend,
    input  logic [width-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [width-1:0] quotient,
    output logic [width-1:0] remainder,
    output logic             div_zero
);

    localparam int CNT_W = $clog2(width);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(width - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [width:0]   r_q;      // partial remainder, one guard bit
    logic [width-1:0] q_q;      // starts as the dividend, fills with quotient bits
    logic [width-1:0] dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic             dz_q;

    logic [width:0]   r_shift;
    logic [width:0]   trial;
    logic [width:0]   r_d;
    logic [width-1:0] q_d;

    // One restoring step: shift {R,Q} left, the dividend MSB (held in the
    // top of Q) drops into R[0]; keep the trial difference if it did not
    // borrow. R stays below the divisor, so its guard bit never overflows.
    always_comb begin
        r_shift = (r_q << 1) | {{width{1'b0}}, q_q[width-1]};
        trial   = r_shift - {1'b0, dvs_q};
        r_d     = r_shift;
        q_d     = {q_q[width-2:0], 1'b0};
        if (!trial[width]) begin
            r_d = trial;
            q_d = {q_q[width-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            r_q       <= '0;
            q_q       <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            dz_q      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        q_q      <= dividend;
                        dvs_q    <= divisor;
                        r_q      <= '0;
                        cnt_q    <= '0;
                        dz_q     <= (divisor == '0);
                        div_zero <= 1'b0;
                        busy     <= 1'b1;
                        state_q  <= (divisor == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    r_q   <= r_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_ITER) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                    if (dz_q) begin
                        // Q was never shifted, so it still holds the dividend.
                        quotient  <= '1;
                        remainder <= q_q;
                        div_zero  <= 1'b1;
                    end else begin
                        quotient  <= q_q;
                        remainder <= r_q[width-1:0];
                        div_zero  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_restoring_divider_module.sv
module tb_restoring_divider_module;

    localparam int W = 4;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;

    restoring_divider_module #(.width(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    typedef struct {
        int q;
        int r;
        int dz;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   done_cnt = 0;
    int   held_q = 0, held_r = 0, held_dz = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // Behavioural reference: plain integer division with the divide-by-zero rule.
    function automatic exp_t model(input int a, input int b, input int accept_cyc);
        exp_t e;
        if (b == 0) begin
            e.q = (1 << W) - 1;
            e.r = a;
            e.dz = 1;
            e.cyc = accept_cyc + 1;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.dz = 0;
            e.cyc = accept_cyc + W + 1;
        end
        return e;
    endfunction

    // Monitor: compares every done pulse against the oldest expectation and
    // checks that results stay put while idle.
    always @(negedge clk) begin
        if (!reset_n) begin
            held_q  = 0;
            held_r  = 0;
            held_dz = 0;
        end else if (done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: q=%0d r=%0d dz=%0d with no divide pending (cycle %0d)",
                         quotient, remainder, div_zero, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", int'(quotient), e.q);
                chk("remainder", int'(remainder), e.r);
                chk("div_zero", int'(div_zero), e.dz);
                chk("done_cycle", cyc, e.cyc);
                chk("busy_at_done", int'(busy), 0);
            end
            held_q  = int'(quotient);
            held_r  = int'(remainder);
            held_dz = int'(div_zero);
        end else if (!busy) begin
            chk("idle_hold", {int'(quotient), int'(remainder), int'(div_zero)} == {held_q, held_r, held_dz} ? 1 : 0, 1);
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", int'(busy), 0);
    endtask

    // Issue one divide; operands are scrambled right after acceptance.
    task automatic do_div(input int a, input int b);
        wait_idle();
        dividend = W'(a);
        divisor  = W'(b);
        start    = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back(model(a, b, cyc));
        @(negedge clk);
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
    endtask

    initial begin
        int k;
        int d0;
        exp_t e;
        reset_n  = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_q", int'(quotient), 0);
        chk("rst_r", int'(remainder), 0);
        chk("rst_dz", int'(div_zero), 0);
        reset_n = 1'b1;

        // Directed cases, including divide by zero and boundary operands.
        do_div(13, 4);
        do_div(15, 1);
        do_div(3, 5);
        do_div(15, 15);
        do_div(7, 0);
        do_div(9, 2);
        do_div(0, 0);
        do_div(15, 0);

        // Start held high through a whole divide while operands wander.
        wait_idle();
        dividend = 4'd10;
        divisor  = 4'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back(model(10, 3, cyc));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) break;
            dividend = W'($urandom);
            divisor  = W'($urandom);
        end
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pulsed_start_sb_empty", sb.size(), 0);

        // Start held continuously: second divide accepted on the first idle cycle.
        wait_idle();
        dividend = 4'd15;
        divisor  = 4'd2;
        start    = 1'b1;
        @(posedge clk);
        #1;
        k = cyc;
        e = model(15, 2, k);
        sb.push_back(e);
        e = model(15, 2, k + W + 2);
        sb.push_back(e);
        repeat (2 * W + 3) @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("continuous_start_sb_empty", sb.size(), 0);

        // Reset during RUN abandons the divide.
        do_div(14, 3);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_q", int'(quotient), 0);
        chk("abort_r", int'(remainder), 0);
        sb.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        d0 = done_cnt;
        repeat (10) @(negedge clk);
        chk("abort_no_done", done_cnt, d0);
        chk("abort_idle_busy", int'(busy), 0);
        do_div(14, 3);

        // Exhaustive sweep with random idle gaps between requests.
        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 0; b < (1 << W); b++) begin
                do_div(a, b);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end

        // Random operands.
        for (int i = 0; i < 40; i++) begin
            do_div(int'($urandom_range(0, (1 << W) - 1)), int'($urandom_range(0, (1 << W) - 1)));
        end

        begin
            int n;
            n = 0;
            while (sb.size() != 0 && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        chk("sb_drain", sb.size(), 0);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
